// File: rtl/eca_pkg.sv
// Shared types and constants for the elementary cellular automaton engine.
package eca_pkg;

  localparam int RULE_W            = 8;
  localparam int BOUNDARY_PERIODIC = 0;
  localparam int BOUNDARY_ZERO     = 1;

  typedef enum logic {IDLE, RUN} state_t;

  // Truth-table order: bit 7 holds the result for pattern 000, bit 0 for 111.
  function automatic logic rule_bit(input logic [RULE_W-1:0] rule, input logic [2:0] v);
    return rule[3'd7 - v];
  endfunction

endpackage

// File: rtl/eca_rule_engine_if.sv
// Control/data bundle between a requester and the rule engine.
interface eca_rule_engine_if import eca_pkg::*; #(
  parameter int CELLS  = 16,
  parameter int STEP_W = 8
);
  logic [RULE_W-1:0] rule;
  logic              load_valid;
  logic              load_ready;
  logic [CELLS-1:0]  load_data;
  logic              start;
  logic [STEP_W-1:0] steps;
  logic              abort;
  logic              busy;
  logic              done;
  logic              stable;
  logic [STEP_W-1:0] step_count;
  logic [CELLS-1:0]  cells_out;

  modport master (
    output rule, load_valid, load_data, start, steps, abort,
    input  load_ready, busy, done, stable, step_count, cells_out
  );

  modport slave (
    input  rule, load_valid, load_data, start, steps, abort,
    output load_ready, busy, done, stable, step_count, cells_out
  );
endinterface

// File: rtl/eca_next_gen.sv
// Combinational next-generation lookup for every cell of the automaton.
module eca_next_gen import eca_pkg::*; #(
  parameter int CELLS    = 16,
  parameter int BOUNDARY = BOUNDARY_PERIODIC
) (
  input  logic [RULE_W-1:0] rule,
  input  logic [CELLS-1:0]  cur,
  output logic [CELLS-1:0]  next
);

  // Left neighbour is the higher index, right neighbour the lower index.
  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    logic l, r;

    if (i == CELLS - 1) begin : g_l_edge
      assign l = (BOUNDARY == BOUNDARY_ZERO) ? 1'b0 : cur[0];
    end else begin : g_l_mid
      assign l = cur[i+1];
    end

    if (i == 0) begin : g_r_edge
      assign r = (BOUNDARY == BOUNDARY_ZERO) ? 1'b0 : cur[CELLS-1];
    end else begin : g_r_mid
      assign r = cur[i-1];
    end

    assign next[i] = rule_bit(rule, {l, cur[i], r});
  end

endmodule

// File: rtl/eca_rule_engine.sv
// Elementary CA engine: load a generation, then step it once per clock under a latched rule.
module eca_rule_engine import eca_pkg::*; #(
  parameter int CELLS      = 16,
  parameter int STEP_W     = 8,
  parameter int BOUNDARY   = BOUNDARY_PERIODIC,
  parameter int EARLY_STOP = 0
) (
  input  logic clk,
  input  logic rst,
  eca_rule_engine_if.slave bus
);

  state_t            state;
  logic [RULE_W-1:0] rule_q;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] cnt;
  logic [CELLS-1:0]  cells;
  logic [CELLS-1:0]  nxt;
  logic              done_q;
  logic              stable_q;

  logic [STEP_W:0]   cnt_p1;
  logic [STEP_W-1:0] cnt_inc;
  logic              last;
  logic              same;

  eca_next_gen #(.CELLS(CELLS), .BOUNDARY(BOUNDARY)) u_next (
    .rule (rule_q),
    .cur  (cells),
    .next (nxt)
  );

  // Extra bit keeps the completion compare exact even at the counter ceiling.
  assign cnt_p1  = {1'b0, cnt} + 1'b1;
  assign cnt_inc = (&cnt) ? cnt : cnt_p1[STEP_W-1:0];
  assign last    = (cnt_p1 == {1'b0, steps_q});
  assign same    = (nxt == cells);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rule_q   <= '0;
      steps_q  <= '0;
      cnt      <= '0;
      cells    <= '0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_valid) begin
            cells    <= bus.load_data;
            stable_q <= 1'b0;
          end
          if (bus.start) begin
            rule_q   <= bus.rule;
            steps_q  <= bus.steps;
            cnt      <= '0;
            stable_q <= 1'b0;
            if (bus.steps == '0) done_q <= 1'b1;
            else                 state  <= RUN;
          end
        end
        RUN: begin
          // Abort wins over completion and freezes the generation and count.
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            cells    <= nxt;
            cnt      <= cnt_inc;
            stable_q <= same;
            if (last || ((EARLY_STOP != 0) && same)) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.busy       = (state == RUN);
  assign bus.done       = done_q;
  assign bus.stable     = stable_q;
  assign bus.step_count = cnt;
  assign bus.cells_out  = cells;

endmodule

// File: tb/tb_eca_rule_engine.sv
// Directed bench: three engines (periodic, zero-boundary, early-stop) share one stimulus stream.
module tb_eca_rule_engine;
  import eca_pkg::*;

  localparam int CELLS  = 8;
  localparam int STEP_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rule, load_data, steps;
  logic       load_valid, start, abort;

  logic [2:0]       rdy_v, busy_v, done_v, stable_v;
  logic [2:0][7:0]  cells_v, cnt_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    eca_rule_engine_if #(.CELLS(CELLS), .STEP_W(STEP_W)) bus ();
    assign bus.rule       = rule;
    assign bus.load_valid = load_valid;
    assign bus.load_data  = load_data;
    assign bus.start      = start;
    assign bus.steps      = steps;
    assign bus.abort      = abort;
    assign rdy_v[g]       = bus.load_ready;
    assign busy_v[g]      = bus.busy;
    assign done_v[g]      = bus.done;
    assign stable_v[g]    = bus.stable;
    assign cnt_v[g]       = bus.step_count;
    assign cells_v[g]     = bus.cells_out;

    eca_rule_engine #(
      .CELLS(CELLS), .STEP_W(STEP_W),
      .BOUNDARY((g == 1) ? 1 : 0), .EARLY_STOP((g == 2) ? 1 : 0)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  int total = 0;
  int bad   = 0;
  int lat0, lat1, lat2;
  bit saw_busy, dbl;

  typedef struct {
    logic [7:0] rule, load, steps;
    logic [7:0] c0, c1, cnt;
    logic       s0, s1;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: next(i) = rule[7 - {left, centre, right}], left = i+1.
  function automatic logic [7:0] ref_step(input logic [7:0] r, input logic [7:0] c, input bit zero);
    logic [7:0] n;
    for (int i = 0; i < 8; i++) begin
      int  v;
      logic lb, rb;
      lb = (i == 7) ? (zero ? 1'b0 : c[0]) : c[i+1];
      rb = (i == 0) ? (zero ? 1'b0 : c[7]) : c[i-1];
      v  = {29'd0, lb, c[i], rb};
      n[i] = r[7-v];
    end
    return n;
  endfunction

  task automatic start_run(input logic [7:0] r, input logic [7:0] ld, input logic [7:0] st, input bit same);
    if (!same) begin
      load_data = ld; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
    end
    rule = r; steps = st; start = 1'b1;
    if (same) begin
      load_data = ld; load_valid = 1'b1;
    end
    step();
    // Scramble inputs right after the start edge; the run must use latched values.
    start = 1'b0; load_valid = 1'b0;
    rule = ~r; steps = 8'hFF; load_data = ~ld;
  endtask

  // Latency counted in clock edges after the start edge.
  task automatic wait_all();
    int cyc;
    logic [2:0] prev;
    cyc = 0; prev = '0;
    lat0 = -1; lat1 = -1; lat2 = -1;
    saw_busy = 0; dbl = 0;
    while ((lat0 < 0 || lat1 < 0) && cyc < 300) begin
      if (busy_v[0]) saw_busy = 1;
      if (done_v[0] && lat0 < 0) lat0 = cyc;
      if (done_v[1] && lat1 < 0) lat1 = cyc;
      if (done_v[2] && lat2 < 0) lat2 = cyc;
      if (|(prev & done_v)) dbl = 1;
      prev = done_v;
      step();
      cyc++;
    end
  endtask

  initial begin
    logic [7:0] exp_c;
    bit seen;
    int lat;

    vt[0] = '{8'h9C, 8'h10, 8'd1, 8'hCF, 8'hCF, 8'd1, 1'b0, 1'b0};
    vt[1] = '{8'h0F, 8'h81, 8'd1, 8'hC0, 8'h40, 8'd1, 1'b0, 1'b0};
    vt[2] = '{8'h33, 8'h5A, 8'd3, 8'h5A, 8'h5A, 8'd3, 1'b1, 1'b1};
    vt[3] = '{8'h0F, 8'h01, 8'd8, 8'h01, 8'h00, 8'd8, 1'b0, 1'b1};
    vt[4] = '{8'hAA, 8'h00, 8'd2, 8'h00, 8'h01, 8'd2, 1'b0, 1'b0};
    vt[5] = '{8'h9C, 8'h3C, 8'd0, 8'h3C, 8'h3C, 8'd0, 1'b0, 1'b0};

    rule = 0; load_data = 0; steps = 0; load_valid = 0; start = 0; abort = 0;
    #3;
    chk("rst_cells",  cells_v[0], 0);
    chk("rst_cnt",    cnt_v[0], 0);
    chk("rst_busy",   busy_v[0], 0);
    chk("rst_done",   done_v[0], 0);
    chk("rst_stable", stable_v[0], 0);
    chk("rst_ready",  rdy_v[0], 1);
    step(); step();
    rst = 1'b0;
    step();

    for (int k = 0; k < 6; k++) begin
      start_run(vt[k].rule, vt[k].load, vt[k].steps, 1'b0);
      wait_all();
      chk($sformatf("v%0d_lat", k),     lat0, {24'd0, vt[k].steps});
      chk($sformatf("v%0d_lat_z", k),   lat1, {24'd0, vt[k].steps});
      chk($sformatf("v%0d_cells", k),   cells_v[0], vt[k].c0);
      chk($sformatf("v%0d_cells_z", k), cells_v[1], vt[k].c1);
      chk($sformatf("v%0d_cnt", k),     cnt_v[0], vt[k].cnt);
      chk($sformatf("v%0d_stable", k),  stable_v[0], vt[k].s0);
      chk($sformatf("v%0d_stable_z", k), stable_v[1], vt[k].s1);
      chk($sformatf("v%0d_busy", k),    saw_busy, (vt[k].steps != 0));
      chk($sformatf("v%0d_pulse", k),   dbl, 0);
    end

    // Early stop on the first unchanged generation.
    start_run(8'h00, 8'hA5, 8'd10, 1'b0);
    wait_all();
    chk("es_lat",    lat2, 2);
    chk("es_cells",  cells_v[2], 8'h00);
    chk("es_cnt",    cnt_v[2], 2);
    chk("es_stable", stable_v[2], 1);
    chk("nes_lat",   lat0, 10);
    chk("nes_cnt",   cnt_v[0], 10);

    // Load and start in the same cycle: loaded data is the run's seed.
    start_run(8'h33, 8'h10, 8'd4, 1'b1);
    wait_all();
    chk("sc_lat",    lat0, 4);
    chk("sc_cells",  cells_v[0], 8'h10);
    chk("sc_stable", stable_v[0], 1);
    chk("sc_cnt",    cnt_v[0], 4);

    // Abort after five generations.
    exp_c = 8'h10;
    repeat (5) exp_c = ref_step(8'h9C, exp_c, 1'b0);
    start_run(8'h9C, 8'h10, 8'd20, 1'b0);
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    seen = done_v[0];
    chk("ab_busy",  busy_v[0], 0);
    chk("ab_cnt",   cnt_v[0], 5);
    chk("ab_cells", cells_v[0], exp_c);
    repeat (3) begin
      step();
      seen = seen | done_v[0];
    end
    chk("ab_nodone", seen, 0);

    // Start and load during RUN are ignored.
    exp_c = 8'h10;
    repeat (6) exp_c = ref_step(8'h9C, exp_c, 1'b0);
    start_run(8'h9C, 8'h10, 8'd6, 1'b0);
    step(); step();
    start = 1'b1; rule = 8'h00; steps = 8'd1; load_valid = 1'b1; load_data = 8'hFF;
    step();
    start = 1'b0; load_valid = 1'b0;
    wait_all();
    chk("ig_lat",   lat0, 3);
    chk("ig_cells", cells_v[0], exp_c);
    chk("ig_cnt",   cnt_v[0], 6);

    // Asynchronous reset mid-run, then a fresh run.
    start_run(8'h9C, 8'h10, 8'd20, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    #2;
    chk("mr_cells",  cells_v[0], 0);
    chk("mr_cnt",    cnt_v[0], 0);
    chk("mr_busy",   busy_v[0], 0);
    chk("mr_stable", stable_v[0], 0);
    chk("mr_ready",  rdy_v[0], 1);
    step();
    rst = 1'b0;
    step();
    start_run(8'h9C, 8'h10, 8'd1, 1'b0);
    wait_all();
    lat = lat0;
    chk("fr_lat",   lat, 1);
    chk("fr_cells", cells_v[0], 8'hCF);
    chk("fr_cnt",   cnt_v[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eca_rule_engine.md
Name: eca_rule_engine

Overview:
- Parametrised sequential successor to the fixed 3-input truth-table gates: a one-dimensional elementary cellular automaton of CELLS cells.
- The 8-bit Wolfram rule is a runtime input, e.g. 0x9C.
- Loads an initial generation, then advances one generation per clock for a requested step count, with a done handshake.
- Used as a reusable rule evaluator and stimulus generator for the wolfram rule-family circuits.

Parameters:
- CELLS, 16, number of cells; must be at least 3.
- STEP_W, 8, width of the step count and step counter.
- BOUNDARY, 0, boundary mode: 0 = periodic wrap, 1 = fixed-zero ends.
- EARLY_STOP, 0, when 1 the run terminates on the first generation that produces no change.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rule  in  8  Wolfram rule; latched on start.
- load_valid  in  1  initial-generation write request.
- load_ready  out  1  high only in IDLE.
- load_data  in  CELLS  initial generation.
- start  in  1  run request; honoured only in IDLE.
- steps  in  STEP_W  number of generations to compute; latched on start.
- abort  in  1  ends RUN early.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at run completion.
- stable  out  1  last computed generation equalled its predecessor.
- step_count  out  STEP_W  generations computed in the current or last run.
- cells_out  out  CELLS  current generation, registered.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, cells_out=0, step_count=0, done=0, stable=0, busy=0; latched rule and steps = 0. Reset mid-run discards the run immediately.
- Neighbourhood of cell i: left = cell i+1, centre = cell i, right = cell i-1.
- Pattern v = {left, centre, right}; next(i) = rule[7 - v]. Rule bit 7 is pattern 000 and bit 0 is pattern 111, which is the codebase truth-table order.
- Edge cells, BOUNDARY=0: left of cell CELLS-1 is cell 0; right of cell 0 is cell CELLS-1.
- Edge cells, BOUNDARY=1: out-of-range neighbours read 0.
- States: IDLE, RUN. load_ready = (state==IDLE); busy = (state==RUN).
- IDLE with load_valid: cells_out <= load_data; stable <= 0.
- IDLE with start: latch rule and steps; step_count <= 0; stable <= 0.
  - steps==0: stay IDLE; done=1 next cycle; cells unchanged.
  - otherwise go to RUN.
- IDLE with load_valid and start in the same cycle: both accepted. load_data is the initial generation of the run.
- RUN, each cycle:
  - cells_out <= next generation; step_count += 1; stable <= (next == cells_out).
  - When step_count+1 == latched steps: go to IDLE and pulse done.
- Latency: done is asserted exactly N cycles after the start edge for steps = N > 0.
- EARLY_STOP=1: if next == cells_out in RUN, that update still counts; go to IDLE with a done pulse.
- abort in RUN: go to IDLE, no done pulse, no update that cycle; cells_out and step_count hold.
- abort in IDLE: ignored. abort has priority over completion in the same cycle.
- start or load_valid while in RUN: ignored, no effect.
- Changes on rule or steps after start: no effect on the current run.
- step_count saturates at 2^STEP_W - 1 (unreachable with correct steps); it never wraps.

Decomposition:
- Shared package eca_pkg:
  - state enum {IDLE, RUN};
  - RULE_W = 8;
  - BOUNDARY_PERIODIC = 0, BOUNDARY_ZERO = 1.
- One combinational sub-module, eca_next_gen: parameters CELLS and BOUNDARY; inputs rule and cur; output next.
  - It is the rule lookup for all cells and is reused by the verification reference model.
- The FSM, counter and registers live in eca_rule_engine.

Test Plan (CELLS=8 unless stated):
1. BOUNDARY=0, rule 0x9C, load 0x10, steps=1 -> done 1 cycle after start; cells_out=0xCF; step_count=1; stable=0.
2. Rule 0x0F (shift from left), load 0x81, steps=1: BOUNDARY=0 -> 0xC0; BOUNDARY=1 -> 0x40.
3. EARLY_STOP=1, rule 0x00, load 0xA5, steps=10 -> 0x00 after step 1; done after 2 cycles; step_count=2; stable=1. With EARLY_STOP=0 -> done after 10 cycles; step_count=10.
4. steps=0 with load 0x3C -> done next cycle, busy never high, cells_out=0x3C, step_count=0. Same-cycle load_valid+start with load 0x10, rule 0x33 (identity), steps=4 -> cells_out=0x10; stable=1.
5. Rule 0x9C, steps=20: abort at cycle 5 -> IDLE, no done, step_count=5. rst asserted mid-run -> all outputs 0 asynchronously; a fresh run then completes normally.
6. start and load_valid pulsed during RUN -> ignored; run result matches the software model for the original rule and steps.
